// File: rtl/tty_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tty_pkg
//  Description : Shared definitions for the glass-TTY text writer.
//                FSM state encoding, control-code values, cursor register
//                indices and the address / byte-enable helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package tty_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUT      = 3'd1,
    ST_SCR_RD   = 3'd2,
    ST_SCR_WAIT = 3'd3,
    ST_SCR_WR   = 3'd4,
    ST_CLR      = 3'd5,
    ST_CUR_X    = 3'd6,
    ST_CUR_Y    = 3'd7
  } tty_state_e;

  // Control codes acted upon; everything else outside the printable range
  // is swallowed.
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  // Display cursor register indices (land in hid_addr[8:3]).
  localparam logic [5:0] CUR_X_REG = 6'd2;
  localparam logic [5:0] CUR_Y_REG = 6'd3;

  // Text RAM rows are always 32 words of 4 cells, independent of COLS.
  localparam logic [10:0] ROW_WORDS = 11'd32;

  // Byte address of 64-bit text RAM word w.
  function automatic logic [18:0] word_addr(input logic [10:0] w);
    return {5'b0, w, 3'b000};
  endfunction

  // Word index holding cell (x,y).
  function automatic logic [10:0] cell_word(input logic [6:0] x, input logic [5:0] y);
    return {y, x[6:2]};
  endfunction

  function automatic logic [18:0] cell_addr(input logic [6:0] x, input logic [5:0] y);
    return word_addr(cell_word(x, y));
  endfunction

  // Register-space address: bit 14 selects registers, index sits in [8:3].
  function automatic logic [18:0] cur_reg_addr(input logic [5:0] idx);
    return {4'b0000, 1'b1, 5'b00000, idx, 3'b000};
  endfunction

  // Two byte lanes per 16-bit cell, selected by the cell's slot in its word.
  function automatic logic [7:0] byte_en(input logic [1:0] slot);
    return 8'b0000_0011 << {slot, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tty_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tty_writer
//  Description : Glass-TTY front end for the text-mode display. Consumes an
//                ASCII byte stream, writes 16-bit cells {0,attr,ascii} into
//                text RAM over the HID port, scrolls by read-copy, clears on
//                form feed and mirrors the cursor into xcursor/ycursor.
//  Ports       : clk_i/rst_ni          clock, async active-low reset
//                char_valid/data/ready byte input handshake, attr_i colour
//                hid_en/we/addr/wrdata display bus initiator outputs
//                one_hot_data_addr     8'h80 during any bus access
//                hid_rddata            display read data (RD_LAT later)
//                busy                  FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module tty_writer #(
  parameter int COLS   = 128,
  parameter int ROWS   = 32,
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic [6:0]  attr_i,
  output logic        hid_en,
  output logic [7:0]  hid_we,
  output logic [18:0] hid_addr,
  output logic [63:0] hid_wrdata,
  output logic [7:0]  one_hot_data_addr,
  input  logic [63:0] hid_rddata,
  output logic        busy
);

  import tty_pkg::*;

  localparam logic [6:0]  X_MAX         = 7'(COLS - 1);
  localparam logic [5:0]  Y_MAX         = 6'(ROWS - 1);
  localparam logic [10:0] LAST_WORD     = 11'(ROWS * 32 - 1);
  localparam logic [10:0] LAST_ROW_WORD = 11'((ROWS - 1) * 32);
  localparam logic [7:0]  WAIT_LAST     = 8'(RD_LAT - 1);

  tty_state_e  state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [10:0] word_q, word_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  ascii_q, ascii_d;
  logic [6:0]  attr_q, attr_d;
  logic [63:0] rd_q, rd_d;
  logic        newline;
  logic        printable;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      word_q  <= '0;
      wait_q  <= '0;
      ascii_q <= '0;
      attr_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      ascii_q <= ascii_d;
      attr_q  <= attr_d;
      rd_q    <= rd_d;
    end
  end

  assign printable = (char_data >= CH_PRINT_LO) && (char_data <= CH_PRINT_HI);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    word_d     = word_q;
    wait_d     = wait_q;
    ascii_d    = ascii_q;
    attr_d     = attr_q;
    rd_d       = rd_q;
    newline    = 1'b0;
    char_ready = 1'b0;
    hid_en     = 1'b0;
    hid_we     = 8'h00;
    hid_addr   = '0;
    hid_wrdata = '0;

    case (state_q)
      ST_IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          ascii_d = char_data;
          attr_d  = attr_i;
          if (printable) begin
            state_d = ST_PUT;
          end else if (char_data == CH_LF) begin
            newline = 1'b1;
          end else if (char_data == CH_CR) begin
            x_d     = '0;
            state_d = ST_CUR_X;
          end else if (char_data == CH_BS) begin
            if (x_q != '0) x_d = x_q - 7'd1;
            state_d = ST_CUR_X;
          end else if (char_data == CH_FF) begin
            x_d     = '0;
            y_d     = '0;
            word_d  = '0;
            state_d = ST_CLR;
          end
          // Any other byte is consumed and dropped without bus activity.
        end
      end

      ST_PUT: begin
        hid_en     = 1'b1;
        hid_we     = byte_en(x_q[1:0]);
        hid_addr   = cell_addr(x_q, y_q);
        hid_wrdata = {4{1'b0, attr_q, ascii_q}};
        if (x_q < X_MAX) begin
          x_d     = x_q + 7'd1;
          state_d = ST_CUR_X;
        end else begin
          x_d     = '0;
          newline = 1'b1;
        end
      end

      ST_SCR_RD: begin
        hid_en   = 1'b1;
        hid_addr = word_addr(word_q);
        wait_d   = '0;
        state_d  = ST_SCR_WAIT;
      end

      // Read data is valid RD_LAT cycles after the strobe, i.e. during the
      // last wait cycle; capture it there.
      ST_SCR_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          rd_d    = hid_rddata;
          state_d = ST_SCR_WR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_SCR_WR: begin
        hid_en     = 1'b1;
        hid_we     = 8'hFF;
        hid_addr   = word_addr(word_q - ROW_WORDS);
        hid_wrdata = rd_q;
        if (word_q == LAST_WORD) begin
          word_d  = LAST_ROW_WORD;
          state_d = ST_CLR;
        end else begin
          word_d  = word_q + 11'd1;
          state_d = ST_SCR_RD;
        end
      end

      // Shared by scroll (bottom row only) and form feed (whole screen);
      // both finish on the last word of the screen.
      ST_CLR: begin
        hid_en   = 1'b1;
        hid_we   = 8'hFF;
        hid_addr = word_addr(word_q);
        if (word_q == LAST_WORD) begin
          state_d = ST_CUR_X;
        end else begin
          word_d = word_q + 11'd1;
        end
      end

      ST_CUR_X: begin
        hid_en     = 1'b1;
        hid_we     = 8'hFF;
        hid_addr   = cur_reg_addr(CUR_X_REG);
        hid_wrdata = {57'b0, x_q};
        state_d    = ST_CUR_Y;
      end

      ST_CUR_Y: begin
        hid_en     = 1'b1;
        hid_we     = 8'hFF;
        hid_addr   = cur_reg_addr(CUR_Y_REG);
        hid_wrdata = {58'b0, y_q};
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Newline on the bottom row keeps y and scrolls instead.
    if (newline) begin
      if (y_q < Y_MAX) begin
        y_d     = y_q + 6'd1;
        state_d = ST_CUR_X;
      end else begin
        word_d  = ROW_WORDS;
        state_d = ST_SCR_RD;
      end
    end
  end

  assign one_hot_data_addr = hid_en ? 8'h80 : 8'h00;
  assign busy              = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tty_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tty_writer
//  Description : Self-checking bench for tty_writer: vector table of single
//                characters plus directed sequences for BS, wrap, form feed,
//                scroll and reset during scroll.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tty_writer;

  localparam int LIMIT = 5000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [6:0]  attr_i;
  logic        hid_en;
  logic [7:0]  hid_we;
  logic [18:0] hid_addr;
  logic [63:0] hid_wrdata;
  logic [7:0]  one_hot_data_addr;
  logic [63:0] hid_rddata;
  logic        busy;

  always #5 clk_i = ~clk_i;

  tty_writer #(.COLS(128), .ROWS(32), .RD_LAT(1)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .char_valid        (char_valid),
    .char_data         (char_data),
    .char_ready        (char_ready),
    .attr_i            (attr_i),
    .hid_en            (hid_en),
    .hid_we            (hid_we),
    .hid_addr          (hid_addr),
    .hid_wrdata        (hid_wrdata),
    .one_hot_data_addr (one_hot_data_addr),
    .hid_rddata        (hid_rddata),
    .busy              (busy)
  );

  typedef struct {
    logic [7:0]  we;
    logic [18:0] addr;
    logic [63:0] data;
  } acc_t;

  typedef struct {
    logic [7:0]  ch;
    logic [6:0]  attr;
    int          n_acc;
    int          lat;
    logic [7:0]  we0;
    logic [18:0] addr0;
    logic [63:0] data0;
    logic [6:0]  x;
    logic [5:0]  y;
  } vec_t;

  acc_t log_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   proto_err = 0;

  // Display read model: word w reads back as a tag plus (w+1).
  function automatic logic [63:0] rd_model(input logic [10:0] w);
    return 64'hA5A5_0000_0000_0000 | 64'({5'b0, w} + 16'd1);
  endfunction

  always @(posedge clk_i) begin
    if (hid_en && hid_we == 8'h00) hid_rddata <= rd_model(hid_addr[13:3]);
    else                           hid_rddata <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (hid_en) log_q.push_back('{we: hid_we, addr: hid_addr, data: hid_wrdata});
      if (one_hot_data_addr !== (hid_en ? 8'h80 : 8'h00)) proto_err++;
      if (busy !== !char_ready) proto_err++;
      if (hid_en && (hid_addr[2:0] != 3'b0 || hid_addr[18:15] != 4'b0)) proto_err++;
    end
  end

  function automatic logic [95:0] pk(input logic [7:0] we, input logic [18:0] a,
                                     input logic [63:0] d);
    return {5'b0, we, a, d};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_cursor(input string tag, input logic [6:0] x, input logic [5:0] y);
    int n;
    n = log_q.size();
    if (n < 2) begin
      chk({tag, "_cur_count"}, 96'(n), 96'd2);
    end else begin
      chk({tag, "_xwrite"}, pk(log_q[n-2].we, log_q[n-2].addr, log_q[n-2].data),
          pk(8'hFF, 19'h04010, 64'(x)));
      chk({tag, "_ywrite"}, pk(log_q[n-1].we, log_q[n-1].addr, log_q[n-1].data),
          pk(8'hFF, 19'h04018, 64'(y)));
    end
  endtask

  // Must be called right after a falling edge.
  task automatic send(input logic [7:0] c, input logic [6:0] a, output int lat);
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < LIMIT) begin @(negedge clk_i); n++; end
    log_q.delete();
    char_valid = 1'b1;
    char_data  = c;
    attr_i     = a;
    @(negedge clk_i);
    char_valid = 1'b0;
    char_data  = 8'h00;
    lat = 1;
    while (char_ready !== 1'b1 && lat < LIMIT) begin @(negedge clk_i); lat++; end
    if (char_ready !== 1'b1) chk("ready_timeout", {95'b0, char_ready}, 96'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int lat;
    int err;
    int n;
    int idx;

    vecs[0]  = '{8'h41, 7'h07, 3, 4, 8'h03, 19'h00000, {4{16'h0741}}, 7'd1, 6'd0};
    vecs[1]  = '{8'h62, 7'h12, 3, 4, 8'h0C, 19'h00000, {4{16'h1262}}, 7'd2, 6'd0};
    vecs[2]  = '{8'h01, 7'h00, 0, 1, 8'h00, 19'h00000, 64'h0,         7'd0, 6'd0};
    vecs[3]  = '{8'h0D, 7'h00, 2, 3, 8'hFF, 19'h04010, 64'h0,         7'd0, 6'd0};
    vecs[4]  = '{8'h0A, 7'h00, 2, 3, 8'hFF, 19'h04010, 64'h0,         7'd0, 6'd1};
    vecs[5]  = '{8'h43, 7'h7F, 3, 4, 8'h03, 19'h00100, {4{16'h7F43}}, 7'd1, 6'd1};
    vecs[6]  = '{8'h08, 7'h00, 2, 3, 8'hFF, 19'h04010, 64'h0,         7'd0, 6'd1};
    vecs[7]  = '{8'h08, 7'h00, 2, 3, 8'hFF, 19'h04010, 64'h0,         7'd0, 6'd1};
    vecs[8]  = '{8'h7E, 7'h00, 3, 4, 8'h03, 19'h00100, {4{16'h007E}}, 7'd1, 6'd1};
    vecs[9]  = '{8'h7F, 7'h00, 0, 1, 8'h00, 19'h00000, 64'h0,         7'd0, 6'd0};
    vecs[10] = '{8'h20, 7'h40, 3, 4, 8'h0C, 19'h00100, {4{16'h4020}}, 7'd2, 6'd1};
    vecs[11] = '{8'h1B, 7'h00, 0, 1, 8'h00, 19'h00000, 64'h0,         7'd0, 6'd0};

    rst_ni     = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    attr_i     = 7'h00;
    #1;
    chk("rst_ready", {95'b0, char_ready}, 96'd1);
    chk("rst_bus", pk(hid_we, hid_addr, hid_wrdata), 96'd0);
    chk("rst_en_busy_oh", {86'b0, hid_en, busy, one_hot_data_addr}, 96'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // ---- single-character vector table ----
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].ch, vecs[i].attr, lat);
      chk($sformatf("v%0d_lat", i), 96'(lat), 96'(vecs[i].lat));
      chk($sformatf("v%0d_nacc", i), 96'(log_q.size()), 96'(vecs[i].n_acc));
      if (vecs[i].n_acc > 0 && log_q.size() > 0) begin
        chk($sformatf("v%0d_first", i), pk(log_q[0].we, log_q[0].addr, log_q[0].data),
            pk(vecs[i].we0, vecs[i].addr0, vecs[i].data0));
        chk_cursor($sformatf("v%0d", i), vecs[i].x, vecs[i].y);
      end
    end

    // ---- BS from x=5 on row 1 ----
    send(8'h0D, 7'h00, lat);
    for (int i = 0; i < 5; i++) send(8'h78, 7'h03, lat);
    send(8'h08, 7'h00, lat);
    chk("bs5_nacc", 96'(log_q.size()), 96'd2);
    chk_cursor("bs5", 7'd4, 6'd1);

    // ---- form feed: clear 1024 words ----
    send(8'h0C, 7'h00, lat);
    chk("ff_lat", 96'(lat), 96'd1027);
    chk("ff_nacc", 96'(log_q.size()), 96'd1026);
    err = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k >= log_q.size()) err++;
      else if (pk(log_q[k].we, log_q[k].addr, log_q[k].data) !== pk(8'hFF, 19'(k*8), 64'h0)) err++;
    end
    chk("ff_clear_writes", 96'(err), 96'd0);
    chk_cursor("ff", 7'd0, 6'd0);

    // ---- wrap at x=127 on row 0 ----
    for (int i = 0; i < 127; i++) send(8'h71, 7'h01, lat);
    chk_cursor("fill127", 7'd127, 6'd0);
    send(8'h5A, 7'h07, lat);
    chk("wrap_lat", 96'(lat), 96'd4);
    chk("wrap_nacc", 96'(log_q.size()), 96'd3);
    if (log_q.size() > 0)
      chk("wrap_cell", pk(log_q[0].we, log_q[0].addr, log_q[0].data),
          pk(8'hC0, 19'h000F8, {4{16'h075A}}));
    chk_cursor("wrap", 7'd0, 6'd1);

    // ---- down to the bottom row, then scroll ----
    for (int i = 0; i < 30; i++) send(8'h0A, 7'h00, lat);
    chk_cursor("to_bottom", 7'd0, 6'd31);
    send(8'h0A, 7'h00, lat);
    chk("scroll_lat", 96'(lat), 96'd3011);
    chk("scroll_nacc", 96'(log_q.size()), 96'd2018);
    err = 0;
    for (int k = 0; k < 992; k++) begin
      idx = 2 * k;
      if (idx + 1 >= log_q.size()) err++;
      else begin
        if (log_q[idx].we !== 8'h00 || log_q[idx].addr !== 19'((k + 32) * 8)) err++;
        if (pk(log_q[idx+1].we, log_q[idx+1].addr, log_q[idx+1].data) !==
            pk(8'hFF, 19'(k * 8), rd_model(11'(k + 32)))) err++;
      end
    end
    chk("scroll_copy", 96'(err), 96'd0);
    err = 0;
    for (int j = 0; j < 32; j++) begin
      idx = 1984 + j;
      if (idx >= log_q.size()) err++;
      else if (pk(log_q[idx].we, log_q[idx].addr, log_q[idx].data) !==
               pk(8'hFF, 19'((992 + j) * 8), 64'h0)) err++;
    end
    chk("scroll_clear", 96'(err), 96'd0);
    chk_cursor("scroll", 7'd0, 6'd31);

    // ---- reset while scrolling, at the read of word 200 ----
    char_valid = 1'b1;
    char_data  = 8'h0A;
    @(negedge clk_i);
    char_valid = 1'b0;
    n = 0;
    while (!(hid_en === 1'b1 && hid_we === 8'h00 && hid_addr === 19'(200 * 8)) && n < LIMIT) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_word200", {95'b0, (hid_addr === 19'(200 * 8))}, 96'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_bus", pk(hid_we, hid_addr, hid_wrdata), 96'd0);
    chk("midrst_en_busy_oh", {86'b0, hid_en, busy, one_hot_data_addr}, 96'd0);
    chk("midrst_ready", {95'b0, char_ready}, 96'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", {95'b0, char_ready}, 96'd1);
    send(8'h42, 7'h07, lat);
    chk("post_rst_nacc", 96'(log_q.size()), 96'd3);
    if (log_q.size() > 0)
      chk("post_rst_cell", pk(log_q[0].we, log_q[0].addr, log_q[0].data),
          pk(8'h03, 19'h00000, {4{16'h0742}}));
    chk_cursor("post_rst", 7'd1, 6'd0);

    chk("protocol_monitor", 96'(proto_err), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tty_writer.md
Name: tty_writer

Overview:
- Bus initiator that drives the HID write port of the text-mode framebuffer/display block, giving it glass-TTY behaviour.
- Accepts a byte stream of ASCII characters and writes 16-bit character cells into text RAM.
- Maintains the cursor and mirrors it into the display's xcursor/ycursor registers.
- Scrolls by read-copy through the HID read path; clears the screen on form feed.
- Sits between a console source (UART RX / debug FIFO) and the display.

Parameters:
- COLS, 128, text columns (4 cells per 64-bit word; 32 words per row).
- ROWS, 32, text rows (max 64).
- RD_LAT, 1, clk_i cycles from read strobe to valid hid_rddata.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset
- char_valid  in  1  input byte valid
- char_data  in  8  input byte
- char_ready  out  1  byte accepted when valid&&ready
- attr_i  in  7  cell colour {bg[14:12],fg[11:8]}; sampled at accept
- hid_en  out  1  bus access strobe
- hid_we  out  8  byte write enables; 0 = read
- hid_addr  out  19  byte address
- hid_wrdata  out  64  write data
- one_hot_data_addr  out  8  8'h80 while hid_en, else 0
- hid_rddata  in  64  read data from display
- busy  out  1  FSM not IDLE

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - all outputs 0 except char_ready=1.
  - cursor x=0, y=0.
  - FSM=IDLE.
- Reset mid-operation (including mid-scroll): aborts to IDLE immediately. Partially scrolled screen contents are undefined; the cursor is home.
- Cell format:
  - {1'b0, attr, ascii}.
  - Cell (x,y) lives at word {y[5:0], x[6:2]} → hid_addr[13:3]; hid_addr[2:0]=0, hid_addr[18:14]=0.
  - Write: hid_we = 8'b11 << 2*x[1:0]; hid_wrdata = {4{cell}}.
- Cursor register writes:
  - hid_addr[14]=1, [13]=0, [8:3]=2 (X) or 3 (Y); other bits 0.
  - hid_we=8'hFF; hid_wrdata = zero-extended 7-bit value.
- char_ready is high only in IDLE. A byte is accepted on valid&&ready. One bus access per cycle; hid_en is high exactly in access cycles.
- FSM states: IDLE, PUT, SCR_RD, SCR_WAIT, SCR_WR, CLR, CUR_X, CUR_Y.
  - IDLE, printable (0x20–0x7E): → PUT.
  - PUT: write cell at (x,y).
    - x<COLS-1: x+1.
    - else x=0 and newline.
  - IDLE, LF 0x0A: newline.
  - IDLE, CR 0x0D: x=0, → CUR_X.
  - IDLE, BS 0x08: if x>0 then x-1; → CUR_X.
  - IDLE, FF 0x0C: x=0, y=0, clear all rows via CLR; then CUR_X.
  - IDLE, any other byte: accepted and discarded; no bus activity; stays IDLE.
  - Newline:
    - y<ROWS-1: y+1.
    - else y stays ROWS-1 and scroll: → SCR_RD.
- Scroll:
  - For word w = 32 … ROWS*32-1: SCR_RD issues a read (hid_en=1, hid_we=0, addr w); SCR_WAIT for RD_LAT cycles; SCR_WR writes the captured word to w-32 with hid_we=8'hFF.
  - Then CLR writes zero to the 32 words of row ROWS-1; then CUR_X.
  - Default-parameter cost: 31*32*3 + 32 = 3008 access-path cycles.
- FF clear: CLR writes zero to all ROWS*32 words, ascending.
- Every character-handling path ends CUR_X → CUR_Y → IDLE. Both writes are always issued, even if the value is unchanged.
- Printable latency: accept at cycle 0; PUT at 1; CUR_X at 2; CUR_Y at 3; char_ready high at 4.
- Arithmetic: x is 7 bits, y is 6 bits; no wrap beyond COLS-1 / ROWS-1. Word counter is 11 bits.

Decomposition:
- Package tty_pkg holds:
  - FSM state enum.
  - Control codes (LF, CR, BS, FF).
  - Cursor register indices (2, 3).
  - Function for cell-address formation.
  - Function for byte-enable formation.
- Optional sub-module tty_scroll_engine: the read/wait/write copy loop plus clear counter, with start/done handshake.

Test Plan:
- Reset, then 'A' (0x41) with attr 7'h07:
  - write addr 0, we=8'h03, wrdata 16'h0741 replicated.
  - then X write data 1, Y write data 0.
  - char_ready low 4 cycles.
- x=127,y=0, send 'Z': cell written with we=8'hC0 at word 31; cursor becomes (0,1).
- y=31, send LF:
  - model returns word w+1 on a read of word w (hid_rddata).
  - expect 992 read/write pairs, each read at w and write at w-32 carrying the read data.
  - then 32 zero writes at words 992–1023.
  - cursor stays (0,31).
- x=5, send BS → X write 4; at x=0, BS → X write 0; no cell writes in either case.
- Send 0x0C: 1024 zero writes with we=8'hFF, then X=0, Y=0.
- Assert rst_ni low during the scroll at word 200: outputs go 0 asynchronously; after release, char_ready=1 and the next 'B' writes addr 0.
